serial_seq_tx: RTL and testbench



---
 rtl/serial_seq_tx_pkg.sv | 18 +
 rtl/serial_seq_tx_piso_shift.sv | 28 ++
 rtl/serial_seq_tx.sv | 168 ++++++++++++++++
 tb/tb_serial_seq_tx.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_seq_tx_pkg.sv
// rtl/serial_seq_tx_pkg.sv - shared state encoding, bench patterns and sizing helper
package serial_seq_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SEND = 2'b01,
    S_GAP  = 2'b10
  } state_t;

  localparam logic [3:0] PAT_1010 = 4'b1010;
  localparam logic [3:0] PAT_1101 = 4'b1101;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/serial_seq_tx_piso_shift.sv
// rtl/serial_seq_tx_piso_shift.sv - parallel-in serial-out shift register, MSB first
module serial_seq_tx_piso_shift #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_data,
  output logic         o_msb
);

  logic [W-1:0] r_q;

  // Load takes priority over shift; zeros fill in from the LSB end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= {r_q[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_q[W-1];

endmodule

// File: rtl/serial_seq_tx.sv
// rtl/serial_seq_tx.sv - repeating serial pattern transmitter with optional inter-repetition gap
module serial_seq_tx
  import serial_seq_tx_pkg::*;
#(
  parameter int W     = 4,
  parameter int REP_W = 3,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [W-1:0]     pat,
  input  logic [REP_W-1:0] reps,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = cnt_w(W - 1);
  localparam int GAP_W = cnt_w(GAP);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  state_t           r_state;
  logic [W-1:0]     r_pat;
  logic [BIT_W-1:0] r_bit;
  logic [REP_W-1:0] r_rep;
  logic [GAP_W-1:0] r_gap;
  logic             r_x;
  logic             r_xv;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last_bit;
  logic             w_more;
  logic             w_restart;
  logic             w_load;
  logic             w_shift;
  logic [W-1:0]     w_load_data;
  logic             w_sr_msb;

  // The MSB goes straight to x on (re)start, so the shifter holds only the
  // remaining bits and its MSB is always the next bit to present.
  always_comb begin
    w_accept    = (r_state == S_IDLE) && start && (reps != '0);
    w_last_bit  = (r_state == S_SEND) && (r_bit == '0);
    w_more      = (r_rep > REP_W'(1));
    w_restart   = !abort &&
                  ((w_last_bit && w_more && (GAP == 0)) ||
                   ((r_state == S_GAP) && (r_gap == '0)));
    w_load      = w_accept || w_restart;
    w_shift     = !abort && (r_state == S_SEND) && !w_last_bit;
    w_load_data = w_accept ? {pat[W-2:0], 1'b0} : {r_pat[W-2:0], 1'b0};
  end

  serial_seq_tx_piso_shift #(
    .W(W)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_msb   (w_sr_msb)
  );

  // Sequencer: IDLE -> SEND (-> GAP -> SEND)* -> IDLE, abort wins over all moves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_bit   <= '0;
      r_rep   <= '0;
      r_gap   <= '0;
      r_x     <= 1'b0;
      r_xv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_x    <= 1'b0;
          r_xv   <= 1'b0;
          r_busy <= 1'b0;
          if (start) begin
            if (reps != '0) begin
              r_pat   <= pat;
              r_rep   <= reps;
              r_bit   <= BIT_TOP;
              r_x     <= pat[W-1];
              r_xv    <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= S_SEND;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_bit   <= '0;
            r_rep   <= '0;
            r_gap   <= '0;
            r_x     <= 1'b0;
            r_xv    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_bit != '0) begin
            r_bit <= r_bit - BIT_W'(1);
            r_x   <= w_sr_msb;
          end else if (w_more) begin
            r_rep <= r_rep - REP_W'(1);
            if (GAP > 0) begin
              r_state <= S_GAP;
              r_gap   <= GAP_LOAD;
              r_x     <= 1'b0;
              r_xv    <= 1'b0;
            end else begin
              r_bit <= BIT_TOP;
              r_x   <= r_pat[W-1];
            end
          end else begin
            r_state <= S_IDLE;
            r_rep   <= '0;
            r_x     <= 1'b0;
            r_xv    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_GAP: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_bit   <= '0;
            r_rep   <= '0;
            r_gap   <= '0;
            r_x     <= 1'b0;
            r_xv    <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_gap == '0) begin
            r_state <= S_SEND;
            r_bit   <= BIT_TOP;
            r_x     <= r_pat[W-1];
            r_xv    <= 1'b1;
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_x     <= 1'b0;
          r_xv    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign x       = r_x;
  assign x_valid = r_xv;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_serial_seq_tx.sv
// tb/tb_serial_seq_tx.sv - self-checking bench for serial_seq_tx (GAP=1 and GAP=0 instances)
module tb_serial_seq_tx;
  import serial_seq_tx_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       st0, st1, abort;
  logic [3:0] pat;
  logic [2:0] reps;
  logic       x0, v0, b0, d0;
  logic       x1, v1, b1, d1;

  int n_pass = 0;
  int n_total = 0;
  logic [3:0] exp_q[$];
  logic [3:0] det_sr;
  int det_hits;

  always #5 clk = ~clk;

  serial_seq_tx #(.W(4), .REP_W(3), .GAP(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(st0), .abort(abort), .pat(pat), .reps(reps),
    .x(x0), .x_valid(v0), .busy(b0), .done(d0)
  );

  serial_seq_tx #(.W(4), .REP_W(3), .GAP(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(st1), .abort(abort), .pat(pat), .reps(reps),
    .x(x1), .x_valid(v1), .busy(b1), .done(d1)
  );

  typedef struct {
    int         sel;
    logic [3:0] p;
    int         n;
    int         exp_busy;
    int         exp_ones;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [3:0] outs(input int sel);
    return (sel != 0) ? {x1, v1, b1, d1} : {x0, v0, b0, d0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference trace {x, x_valid, busy, done} per cycle after the accepting edge.
  task automatic build(input logic [3:0] p, input int n, input int g);
    exp_q = {};
    for (int r = 0; r < n; r++) begin
      for (int b = 3; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
      if (r < n - 1) repeat (g) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
  endtask

  task automatic run(input int sel, input logic [3:0] p, input int n, input bit junk,
                     input int abort_at, output int busy_cnt, output int ones_cnt);
    logic [3:0] o;
    build(p, n, (sel != 0) ? 1 : 0);
    pat  = p;
    reps = 3'(n);
    if (sel != 0) st1 = 1'b1; else st0 = 1'b1;
    step();
    st0 = 1'b0;
    st1 = 1'b0;
    busy_cnt = 0;
    ones_cnt = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      o = outs(sel);
      chk($sformatf("trace[%0d] sel=%0d pat=%b n=%0d", i, sel, p, n), int'(o), int'(exp_q[i]));
      if (o[1]) busy_cnt++;
      if (o[3] && o[2]) ones_cnt++;
      if (sel == 0 && o[2]) begin
        det_sr = {det_sr[2:0], o[3]};
        if (det_sr == PAT_1101) det_hits++;
      end
      if (i == abort_at && exp_q[i][1]) begin
        st0 = 1'b0;
        st1 = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_clear", int'(outs(sel)), 0);
        repeat (3) begin
          step();
          chk("abort_no_done", int'(outs(sel)), 0);
        end
        return;
      end
      if (junk && exp_q[i][1]) begin
        if (sel != 0) st1 = 1'($urandom); else st0 = 1'($urandom);
        pat  = 4'($urandom);
        reps = 3'($urandom);
      end else begin
        st0 = 1'b0;
        st1 = 1'b0;
      end
      step();
    end
    st0 = 1'b0;
    st1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int bc, oc, sel, n, ab;
    logic [3:0] p;

    tbl[0] = '{1, PAT_1010, 1, 4, 2};
    tbl[1] = '{1, PAT_1101, 2, 9, 6};
    tbl[2] = '{0, PAT_1101, 3, 12, 9};
    tbl[3] = '{1, 4'b0001, 7, 34, 7};
    tbl[4] = '{1, 4'b1111, 0, 0, 0};
    tbl[5] = '{0, 4'b1000, 2, 8, 2};

    reset = 1'b1; st0 = 1'b0; st1 = 1'b0; abort = 1'b0; pat = '0; reps = '0;
    det_sr = '0; det_hits = 0;
    step();
    step();
    chk("reset_state", int'({outs(0), outs(1)}), 0);
    reset = 1'b0;
    repeat (5) begin
      step();
      chk("idle_after_reset", int'({outs(0), outs(1)}), 0);
    end

    foreach (tbl[k]) begin
      run(tbl[k].sel, tbl[k].p, tbl[k].n, 1'b0, -1, bc, oc);
      chk($sformatf("busy_cycles[%0d]", k), bc, tbl[k].exp_busy);
      chk($sformatf("one_bits[%0d]", k), oc, tbl[k].exp_ones);
    end

    run(1, PAT_1101, 2, 1'b1, -1, bc, oc);
    chk("busy_with_ignored_starts", bc, 9);

    run(1, PAT_1010, 2, 1'b0, 2, bc, oc);
    run(0, PAT_1101, 3, 1'b0, 6, bc, oc);

    pat = PAT_1101; reps = 3'd1; st1 = 1'b1;
    step();
    st1 = 1'b0;
    step();
    chk("pre_reset_bit2", int'(outs(1)), int'(4'b1110));
    #2 reset = 1'b1;
    #1 chk("async_reset_clear", int'(outs(1)), 0);
    step();
    reset = 1'b0;
    step();
    run(1, PAT_1101, 1, 1'b0, -1, bc, oc);
    chk("after_reset_ones", oc, 3);

    det_sr = '0;
    det_hits = 0;
    run(0, PAT_1101, 3, 1'b0, -1, bc, oc);
    chk("loopback_detect_count", det_hits, 3);

    for (int it = 0; it < 25; it++) begin
      sel = int'($urandom_range(0, 1));
      p   = 4'($urandom);
      n   = int'($urandom_range(0, 7));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      run(sel, p, n, 1'b1, ab, bc, oc);
      if (ab < 0) begin
        chk("rand_busy_cycles", bc, n * 4 + ((n > 0) ? (n - 1) * sel : 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
